// File: rtl/przesuniecie_arytm.sv
// przesuniecie_arytm: registered signed left shift with error/overflow flags, 1-cycle latency.
// Define PRZESUNIECIE_SAT_EN to saturate o_result on overflow instead of wrapping.
module przesuniecie_arytm #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    output logic [BITS-1:0] o_result,
    output logic            o_error,
    output logic            o_overflow
);
    logic            w_neg;
    logic            w_big;
    logic            w_ovf;
    logic [BITS-1:0] w_shl;
    logic [BITS-1:0] w_sat;
    logic [BITS-1:0] w_res;
    logic [BITS-1:0] r_result;
    logic            r_error;
    logic            r_overflow;

    // B is range-checked at full width, so huge positive amounts never alias to small ones
    assign w_neg = i_arg_B[BITS-1];
    assign w_big = !w_neg && (65'(i_arg_B) >= 65'(BITS));
    assign w_shl = i_arg_A << i_arg_B;
    // a shift is lossless exactly when shifting back arithmetically recovers A
    assign w_ovf = w_big ? |i_arg_A : (($signed(w_shl) >>> i_arg_B) != $signed(i_arg_A));
    assign w_sat = {i_arg_A[BITS-1], {(BITS-1){~i_arg_A[BITS-1]}}};
`ifdef PRZESUNIECIE_SAT_EN
    assign w_res = w_ovf ? w_sat : w_shl;
`else
    assign w_res = w_big ? '0 : w_shl;
`endif

    always_ff @(posedge i_clk) begin
        r_result   <= (i_rst || w_neg) ? '0 : w_res;
        r_error    <= !i_rst && w_neg;
        r_overflow <= !i_rst && !w_neg && w_ovf;
    end

    assign o_result   = r_result;
    assign o_error    = r_error;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_przesuniecie_arytm.sv
// tb_przesuniecie_arytm: table-driven check of przesuniecie_arytm at BITS=32, plus reset/stream sequences.
module tb_przesuniecie_arytm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] res;
    logic        err_o;
    logic        ovf_o;
    int          errors = 0;
    int          checks = 0;

    przesuniecie_arytm #(.BITS(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_arg_A(a), .i_arg_B(b),
        .o_result(res), .o_error(err_o), .o_overflow(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wrap;
        logic [31:0] sat;
        logic        err;
        logic        ovf;
    } vec_t;

    localparam int NV = 19;
    vec_t v[NV];

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h err=%b ovf=%b, expected res=%h err=%b ovf=%b",
                     name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb);
        longint p;
        logic   o;
        logic [31:0] r;
        if ($signed(mb) < 0) return {32'h0, 1'b1, 1'b0};
        if ($signed(mb) >= 32) begin
            o = (ma != 0);
            r = 32'h0;
        end else begin
            p = longint'($signed(ma)) * (64'sd1 <<< mb[4:0]);
            o = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            r = p[31:0];
        end
`ifdef PRZESUNIECIE_SAT_EN
        if (o) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r, 1'b0, o};
    endfunction

    initial begin
        logic [33:0] exp;
        logic        rs;
        v[0]  = '{32'h0000_0003, 32'd4,         32'h0000_0030, 32'h0000_0030, 1'b0, 1'b0};
        v[1]  = '{32'hFFFF_FFF0, 32'd2,         32'hFFFF_FFC0, 32'hFFFF_FFC0, 1'b0, 1'b0};
        v[2]  = '{32'h1234_5678, 32'd0,         32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
        v[3]  = '{32'h4000_0000, 32'd1,         32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        v[4]  = '{32'hBFFF_FFFF, 32'd1,         32'h7FFF_FFFE, 32'h8000_0000, 1'b0, 1'b1};
        v[5]  = '{32'h0000_0055, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0};
        v[6]  = '{32'h0000_0055, 32'h8000_0001, 32'h0,         32'h0,         1'b1, 1'b0};
        v[7]  = '{32'h0000_0001, 32'd32,        32'h0,         32'h7FFF_FFFF, 1'b0, 1'b1};
        v[8]  = '{32'h0000_0001, 32'h0000_1000, 32'h0,         32'h7FFF_FFFF, 1'b0, 1'b1};
        v[9]  = '{32'h0000_0000, 32'd32,        32'h0,         32'h0,         1'b0, 1'b0};
        v[10] = '{32'h0000_0001, 32'd31,        32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        v[11] = '{32'hFFFF_FFFF, 32'd31,        32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        v[12] = '{32'h8000_0000, 32'd0,         32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        v[13] = '{32'h8000_0000, 32'd1,         32'h0,         32'h8000_0000, 1'b0, 1'b1};
        v[14] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0,         32'h7FFF_FFFF, 1'b0, 1'b1};
        v[15] = '{32'hC000_0000, 32'd1,         32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        v[16] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0};
        v[17] = '{32'h00FF_0000, 32'd8,         32'hFF00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        v[18] = '{32'h00FF_0000, 32'd7,         32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0};

        a = 32'h4000_0000;
        b = 32'd1;
        @(posedge clk); #1;
        chk("reset_0", {res, err_o, ovf_o}, 34'h0);
        b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("reset_1", {res, err_o, ovf_o}, 34'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            a = v[i].a;
            b = v[i].b;
            @(posedge clk); #1;
`ifdef PRZESUNIECIE_SAT_EN
            exp = {v[i].sat, v[i].err, v[i].ovf};
`else
            exp = {v[i].wrap, v[i].err, v[i].ovf};
`endif
            chk($sformatf("vec%0d", i), {res, err_o, ovf_o}, exp);
        end

        a = 32'h0000_0003;
        b = 32'd4;
        @(posedge clk); #1;
        a = 32'h4000_0000;
        b = 32'hFFFF_FFFF;
        #3;
        chk("hold_between_edges", {res, err_o, ovf_o}, {32'h0000_0030, 2'b00});

        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            if (i % 3 == 0) a = {{20{a[31]}}, a[11:0]};
            b = (i % 7 == 5) ? ($urandom() | 32'h8000_0000) : 32'($urandom_range(0, 40));
            rs = (i == 12);
            rst = rs;
            exp = rs ? 34'h0 : model(a, b);
            @(posedge clk); #1;
            rst = 1'b0;
            chk(rs ? "stream_reset" : $sformatf("stream%0d", i), {res, err_o, ovf_o}, exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
